fritz_tmr_pipe: RTL and testbench
=================================

Name: fritz_tmr_pipe

Overview:
- Parametrised, pipelined, triple-modular-redundant successor of the 4-input/3-output Fritz benchmark function, bit-sliced across WIDTH independent lanes.
- Three replicas of the logic are evaluated per beat, with optional per-beat fault injection into one replica and a bitwise majority vote.
- Per-lane mismatch flags and a saturating error counter are produced.
- Sits in the reliability-experiment harness as a fault-injection target with valid/ready streaming I/O.

Parameters:
- WIDTH, 16, number of independent bit lanes.
- CNT_W, 16, width of the error counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- g1, g2, g3, g4  in  WIDTH each  lane operands a, b, c, d.
- vote_en  in  1  1 = majority-voted output; 0 = replica 0 output only. Sampled with the beat.
- inj_rep  in  2  replica to corrupt: 0..2; 3 = no injection. Sampled with the beat.
- inj_mask  in  3*WIDTH  XOR mask on the target replica's outputs: [WIDTH-1:0] g5, [2W-1:W] g6, [3W-1:2W] g7.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- g5, g6, g7  out  WIDTH each  result lanes.
- mismatch  out  WIDTH  per lane: any of the 3 replicas disagree on any of g5/g6/g7.
- err_cnt  out  CNT_W  count of delivered beats with mismatch != 0.
- cnt_clr  in  1  synchronous clear of err_cnt.

Behaviour:
- Per-lane function (golden): g5 = a | (~b & ~c); g6 = ~b & ~c; g7 = (b | c) & ~d.
  - Each replica implements the original 8-gate NAND/NOR/AND/OR structure, not the reduced form, so injection targets real gates.
  - Replicas must not be merged by synthesis: keep-hierarchy on each replica instance.
- Pipeline: 2 stages.
  - S1 registers g1..g4, vote_en, inj_rep and inj_mask on accept.
  - S2 registers replica outputs after injection and vote, plus mismatch.
  - Latency: accept at edge N gives out_valid at edge N+2 when there is no backpressure.
- Handshake:
  - Stage k loads when its upstream is valid and (stage k empty or stage k advancing); it holds when valid and downstream is not ready.
  - in_ready = ~rst & (~s1_v | ~s2_v | out_ready).
  - Full throughput: 1 beat/cycle while out_ready = 1.
  - Data and mismatch must stay stable while out_valid & ~out_ready.
- Injection: replica r output = golden-structure output XOR mask when r == inj_rep; inj_rep = 3 means no corruption.
- Vote:
  - vote_en = 1: bitwise majority of the 3 replicas, so a single-replica fault is masked on g5..g7.
  - vote_en = 0: replica 0 is passed through; a fault injected there is visible.
- mismatch is computed from post-injection replicas regardless of vote_en.
- err_cnt:
  - Increments by 1 on each out_valid & out_ready beat with |mismatch.
  - Saturates at 2^CNT_W - 1 with no wrap.
  - cnt_clr in the same cycle as an increment gives 0; clear wins and that event is dropped.
- Reset, synchronous with priority over everything:
  - s1_v = s2_v = 0, out_valid = 0.
  - g5 = g6 = g7 = 0, mismatch = 0, err_cnt = 0, in_ready = 0.
  - Asserting rst mid-stream drops in-flight beats; nothing is emitted after rst deasserts.

Decomposition:
- Shared package fritz_pkg holds:
  - Replica-count constant N_REP = 3 and the NO_INJ = 2'd3 encoding.
  - Mask-slice offset constants.
  - A golden reference function for benches.
- Natural sub-module: fritz_slice, a pure combinational WIDTH-lane instance of the 8-gate netlist. It is instantiated 3 times.
- Voter and counter stay inline.

Test Plan:
- Exhaustive golden check, WIDTH=16, vote_en=1, inj_rep=3, out_ready=1:
  - Stimulus: g1=16'hFF00, g2=16'hF0F0, g3=16'hCCCC, g4=16'hAAAA (lane i = i[3:0]).
  - Two cycles later: g5=16'hFF03, g6=16'h0303, g7=16'h5454, mismatch=0, err_cnt=0.
- Masked single fault:
  - Stimulus: same inputs, inj_rep=1, inj_mask g6 slice = 16'h0001, vote_en=1.
  - Response: g6=16'h0303, mismatch=16'h0001, err_cnt=1 after the beat.
- Unmasked fault:
  - Stimulus: inj_rep=0, g5 slice mask = 16'h8000, vote_en=0.
  - Response: g5=16'h7F03, mismatch=16'h8000, err_cnt increments.
- Backpressure:
  - Stimulus: 4 back-to-back beats with out_ready held 0 for 5 cycles.
  - Response: in_ready=0 after 2 accepted beats; outputs stable while stalled; all 4 beats delivered in order once out_ready=1; no duplicates.
- Counter saturation and clear, CNT_W=2:
  - Stimulus: 5 faulty beats.
  - Response: err_cnt = 1, 2, 3, 3, 3.
  - Stimulus: cnt_clr with a concurrent faulty beat.
  - Response: err_cnt=0.
- Reset mid-operation:
  - Stimulus: rst pulse for 1 cycle with 2 beats in flight.
  - Response: next cycle out_valid=0, all outputs 0, err_cnt=0, in_ready=0 during rst; no stale beat emitted afterwards.

Source files
------------

// File: rtl/fritz_pkg.sv
// fritz_pkg: shared constants and reference model for the TMR Fritz pipeline.
//   N_REP      number of redundant replicas
//   NO_INJ     inj_rep encoding that disables fault injection
//   G*_SLICE   index of each result inside the packed {g7, g6, g5} vector and
//              inside inj_mask (slice k occupies bits [k*WIDTH +: WIDTH])
//   fritz_golden  single-lane reduced-form reference, returns {g7, g6, g5}
package fritz_pkg;

    localparam int         N_REP    = 3;
    localparam logic [1:0] NO_INJ   = 2'd3;

    localparam int         G5_SLICE = 0;
    localparam int         G6_SLICE = 1;
    localparam int         G7_SLICE = 2;

    function automatic logic [2:0] fritz_golden(input logic a, input logic b,
                                                input logic c, input logic d);
        logic g6;
        g6 = ~b & ~c;
        return {(b | c) & ~d, g6, a | g6};
    endfunction

endpackage

// File: rtl/fritz_slice.sv
// fritz_slice: one replica of the Fritz function, WIDTH independent lanes.
// Built from the original 8-gate NAND/NOR/AND/OR netlist (not the reduced
// form) so every gate output is a distinct fault site.
//   a_i, b_i, c_i, d_i   lane operands
//   g5_o, g6_o, g7_o     lane results
module fritz_slice #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] g5_o,
    output logic [WIDTH-1:0] g6_o,
    output logic [WIDTH-1:0] g7_o
);

    logic [WIDTH-1:0] n_b;
    logic [WIDTH-1:0] n_c;
    logic [WIDTH-1:0] n_d;
    logic [WIDTH-1:0] b_or_c;
    logic [WIDTH-1:0] g7_n;

    assign n_b    = ~(b_i & b_i);       // NAND as inverter
    assign n_c    = ~(c_i | c_i);       // NOR as inverter
    assign n_d    = ~(d_i & d_i);       // NAND as inverter
    assign g6_o   = n_b & n_c;          // AND
    assign g5_o   = a_i | g6_o;         // OR
    assign b_or_c = ~(n_b & n_c);       // NAND -> b | c
    assign g7_n   = ~(b_or_c & n_d);    // NAND
    assign g7_o   = ~(g7_n | g7_n);     // NOR as inverter

endmodule

// File: rtl/fritz_tmr_pipe.sv
// fritz_tmr_pipe: 2-stage valid/ready pipeline around three Fritz replicas with
// optional per-beat fault injection, bitwise majority vote, per-lane mismatch
// flags and a saturating error counter.
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   input handshake
//   g1..g4                lane operands a, b, c, d
//   vote_en               1 = majority result, 0 = replica 0 only
//   inj_rep, inj_mask     replica to corrupt (3 = none) and XOR mask {g7,g6,g5}
//   out_valid / out_ready output handshake
//   g5..g7, mismatch      results and per-lane replica disagreement
//   err_cnt, cnt_clr      delivered-faulty-beat counter and its clear
module fritz_tmr_pipe
    import fritz_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     g1,
    input  logic [WIDTH-1:0]     g2,
    input  logic [WIDTH-1:0]     g3,
    input  logic [WIDTH-1:0]     g4,
    input  logic                 vote_en,
    input  logic [1:0]           inj_rep,
    input  logic [3*WIDTH-1:0]   inj_mask,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     g5,
    output logic [WIDTH-1:0]     g6,
    output logic [WIDTH-1:0]     g7,
    output logic [WIDTH-1:0]     mismatch,
    output logic [CNT_W-1:0]     err_cnt,
    input  logic                 cnt_clr
);

    // Stage 1 registers
    logic                 s1_v_q, s1_v_d;
    logic [WIDTH-1:0]     a_q, b_q, c_q, d_q;
    logic                 vote_q;
    logic [1:0]           inj_rep_q;
    logic [3*WIDTH-1:0]   mask_q;

    // Stage 2 registers
    logic                 s2_v_q, s2_v_d;
    logic [WIDTH-1:0]     g5_q, g6_q, g7_q, mism_q;
    logic [WIDTH-1:0]     g5_d, g6_d, g7_d, mism_d;

    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 s1_load;
    logic                 s2_load;
    logic                 inj_active;

    logic [3*WIDTH-1:0]   rep [N_REP];
    logic [3*WIDTH-1:0]   maj;
    logic [3*WIDTH-1:0]   diff;
    logic [3*WIDTH-1:0]   sel;

    assign in_ready = ~rst & (~s1_v_q | ~s2_v_q | out_ready);
    assign s1_load  = in_valid & in_ready;
    assign s2_load  = s1_v_q & (~s2_v_q | out_ready);

    assign inj_active = (inj_rep_q != NO_INJ);

    for (genvar r = 0; r < N_REP; r++) begin : g_rep
        logic [WIDTH-1:0] g5_w, g6_w, g7_w;
        logic             hit;

        (* keep_hierarchy = "yes" *)
        fritz_slice #(.WIDTH(WIDTH)) u_slice (
            .a_i  (a_q),
            .b_i  (b_q),
            .c_i  (c_q),
            .d_i  (d_q),
            .g5_o (g5_w),
            .g6_o (g6_w),
            .g7_o (g7_w)
        );

        assign hit    = inj_active & (inj_rep_q == 2'(r));
        assign rep[r] = {g7_w, g6_w, g5_w} ^ (hit ? mask_q : '0);
    end

    always_comb begin
        maj    = (rep[0] & rep[1]) | (rep[1] & rep[2]) | (rep[0] & rep[2]);
        // Any replica differing from replica 0 means the three disagree.
        diff   = (rep[0] ^ rep[1]) | (rep[0] ^ rep[2]);
        sel    = vote_q ? maj : rep[0];
        g5_d   = sel[G5_SLICE*WIDTH +: WIDTH];
        g6_d   = sel[G6_SLICE*WIDTH +: WIDTH];
        g7_d   = sel[G7_SLICE*WIDTH +: WIDTH];
        mism_d = diff[G5_SLICE*WIDTH +: WIDTH]
               | diff[G6_SLICE*WIDTH +: WIDTH]
               | diff[G7_SLICE*WIDTH +: WIDTH];
    end

    always_comb begin
        s1_v_d = s1_v_q;
        if (s1_load) begin
            s1_v_d = 1'b1;
        end else if (s2_load) begin
            s1_v_d = 1'b0;
        end

        s2_v_d = s2_v_q;
        if (s2_load) begin
            s2_v_d = 1'b1;
        end else if (out_ready) begin
            s2_v_d = 1'b0;
        end

        // Clear beats a same-cycle increment; saturate instead of wrapping.
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (s2_v_q && out_ready && (|mism_q) && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            d_q       <= '0;
            vote_q    <= 1'b0;
            inj_rep_q <= NO_INJ;
            mask_q    <= '0;
            s2_v_q    <= 1'b0;
            g5_q      <= '0;
            g6_q      <= '0;
            g7_q      <= '0;
            mism_q    <= '0;
            cnt_q     <= '0;
        end else begin
            s1_v_q <= s1_v_d;
            s2_v_q <= s2_v_d;
            cnt_q  <= cnt_d;
            if (s1_load) begin
                a_q       <= g1;
                b_q       <= g2;
                c_q       <= g3;
                d_q       <= g4;
                vote_q    <= vote_en;
                inj_rep_q <= inj_rep;
                mask_q    <= inj_mask;
            end
            if (s2_load) begin
                g5_q   <= g5_d;
                g6_q   <= g6_d;
                g7_q   <= g7_d;
                mism_q <= mism_d;
            end
        end
    end

    assign out_valid = s2_v_q;
    assign g5        = g5_q;
    assign g6        = g6_q;
    assign g7        = g7_q;
    assign mismatch  = mism_q;
    assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_fritz_tmr_pipe.sv
// tb_fritz_tmr_pipe: directed bench for fritz_tmr_pipe (WIDTH=16, CNT_W=2).
module tb_fritz_tmr_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] g1, g2, g3, g4;
    logic        vote_en;
    logic [1:0]  inj_rep;
    logic [47:0] inj_mask;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] g5, g6, g7;
    logic [15:0] mismatch;
    logic [1:0]  err_cnt;
    logic        cnt_clr;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] bp_a [4];
    logic [15:0] bp_b [4];
    logic [15:0] bp_c [4];
    logic [15:0] bp_d [4];
    logic [47:0] bp_exp [4];

    always #5 clk = ~clk;

    fritz_tmr_pipe #(.WIDTH(16), .CNT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .g1        (g1),
        .g2        (g2),
        .g3        (g3),
        .g4        (g4),
        .vote_en   (vote_en),
        .inj_rep   (inj_rep),
        .inj_mask  (inj_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .g5        (g5),
        .g6        (g6),
        .g7        (g7),
        .mismatch  (mismatch),
        .err_cnt   (err_cnt),
        .cnt_clr   (cnt_clr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One isolated beat: accept, observe two edges later, then pipeline drains.
    task automatic run_beat(input string tag,
                            input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d,
                            input logic v, input logic [1:0] r, input logic [47:0] m,
                            input logic [15:0] e5, input logic [15:0] e6,
                            input logic [15:0] e7, input logic [15:0] em);
        g1 = a; g2 = b; g3 = c; g4 = d;
        vote_en = v; inj_rep = r; inj_mask = m;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_ov0"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check({tag, "_ov1"},  64'(out_valid), 64'd1);
        check({tag, "_g5"},   64'(g5), 64'(e5));
        check({tag, "_g6"},   64'(g6), 64'(e6));
        check({tag, "_g7"},   64'(g7), 64'(e7));
        check({tag, "_mism"}, 64'(mismatch), 64'(em));
        @(posedge clk); #1;
        check({tag, "_drain"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc;
        int n_del;
        int stale;

        bp_a[0] = 16'hFFFF; bp_b[0] = 16'h0000; bp_c[0] = 16'h0000; bp_d[0] = 16'h0000;
        bp_a[1] = 16'h0000; bp_b[1] = 16'hFFFF; bp_c[1] = 16'h0000; bp_d[1] = 16'h0000;
        bp_a[2] = 16'h0000; bp_b[2] = 16'h0000; bp_c[2] = 16'hFFFF; bp_d[2] = 16'hFFFF;
        bp_a[3] = 16'h0000; bp_b[3] = 16'h00FF; bp_c[3] = 16'h0000; bp_d[3] = 16'h0000;
        // {g5, g6, g7}
        bp_exp[0] = {16'hFFFF, 16'hFFFF, 16'h0000};
        bp_exp[1] = {16'h0000, 16'h0000, 16'hFFFF};
        bp_exp[2] = {16'h0000, 16'h0000, 16'h0000};
        bp_exp[3] = {16'hFF00, 16'hFF00, 16'h00FF};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        g1 = '0; g2 = '0; g3 = '0; g4 = '0;
        vote_en = 1'b1; inj_rep = 2'd3; inj_mask = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_g5", 64'(g5), 64'd0);
        check("rst_mism", 64'(mismatch), 64'd0);
        check("rst_err", 64'(err_cnt), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Golden, no injection
        run_beat("golden", 16'hFF00, 16'hF0F0, 16'hCCCC, 16'hAAAA, 1'b1, 2'd3, 48'h0,
                 16'hFF03, 16'h0303, 16'h5454, 16'h0000);
        check("golden_err", 64'(err_cnt), 64'd0);

        // Masked single fault on replica 1, g6 lane 0
        run_beat("masked", 16'hFF00, 16'hF0F0, 16'hCCCC, 16'hAAAA, 1'b1, 2'd1,
                 48'h0000_0001_0000, 16'hFF03, 16'h0303, 16'h5454, 16'h0001);
        check("masked_err", 64'(err_cnt), 64'd1);

        // Unmasked fault on replica 0, g5 lane 15, vote disabled
        run_beat("unmasked", 16'hFF00, 16'hF0F0, 16'hCCCC, 16'hAAAA, 1'b0, 2'd0,
                 48'h0000_0000_8000, 16'h7F03, 16'h0303, 16'h5454, 16'h8000);
        check("unmasked_err", 64'(err_cnt), 64'd2);

        // Clear, then saturate a 2-bit counter
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        check("clr_err", 64'(err_cnt), 64'd0);
        for (int i = 0; i < 5; i++) begin
            run_beat("sat", 16'hFF00, 16'hF0F0, 16'hCCCC, 16'hAAAA, 1'b1, 2'd2,
                     48'h8000_0000_0000, 16'hFF03, 16'h0303, 16'h5454, 16'h8000);
            check($sformatf("sat_err%0d", i), 64'(err_cnt), (i >= 2) ? 64'd3 : 64'(i + 1));
        end

        // Clear concurrent with a faulty delivery: clear wins
        g1 = 16'hFF00; g2 = 16'hF0F0; g3 = 16'hCCCC; g4 = 16'hAAAA;
        vote_en = 1'b1; inj_rep = 2'd2; inj_mask = 48'h8000_0000_0000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("clrc_ov", 64'(out_valid), 64'd1);
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        check("clrc_err", 64'(err_cnt), 64'd0);
        check("clrc_drain", 64'(out_valid), 64'd0);

        // Backpressure: out_ready low for cycles 0..4
        vote_en = 1'b1; inj_rep = 2'd3; inj_mask = '0;
        n_acc = 0;
        n_del = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            out_ready = (cyc >= 5);
            in_valid  = (n_acc < 4);
            if (n_acc < 4) begin
                g1 = bp_a[n_acc]; g2 = bp_b[n_acc]; g3 = bp_c[n_acc]; g4 = bp_d[n_acc];
            end
            @(negedge clk);
            if (cyc == 2) begin
                check("bp_in_ready_low", 64'(in_ready), 64'd0);
                check("bp_acc_cnt", 64'(n_acc), 64'd2);
            end
            if (cyc >= 2 && cyc < 5) begin
                check($sformatf("bp_stall_ov%0d", cyc), 64'(out_valid), 64'd1);
                check($sformatf("bp_stall_data%0d", cyc), 64'({g5, g6, g7}), 64'(bp_exp[0]));
            end
            if (out_valid && out_ready) begin
                if (n_del < 4) begin
                    check($sformatf("bp_order%0d", n_del), 64'({g5, g6, g7}), 64'(bp_exp[n_del]));
                end
                n_del++;
            end
            if (in_valid && in_ready) n_acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp_n_acc", 64'(n_acc), 64'd4);
        check("bp_n_del", 64'(n_del), 64'd4);
        check("bp_idle", 64'(out_valid), 64'd0);

        // Reset with two beats in flight
        run_beat("prerst", 16'hFF00, 16'hF0F0, 16'hCCCC, 16'hAAAA, 1'b1, 2'd0,
                 48'h0000_0000_0001, 16'hFF03, 16'h0303, 16'h5454, 16'h0001);
        check("prerst_err", 64'(err_cnt), 64'd1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("midrst_ov_before", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        check("midrst_ov", 64'(out_valid), 64'd0);
        check("midrst_g5", 64'(g5), 64'd0);
        check("midrst_g6", 64'(g6), 64'd0);
        check("midrst_g7", 64'(g7), 64'd0);
        check("midrst_mism", 64'(mismatch), 64'd0);
        check("midrst_err", 64'(err_cnt), 64'd0);
        check("midrst_in_ready2", 64'(in_ready), 64'd0);
        rst = 1'b0;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("postrst_stale", 64'(stale), 64'd0);
        check("postrst_err", 64'(err_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
